// File: rtl/ibus_wait_adapter.sv
// Instruction-bus slave for a zero-latency ROM: adds programmable wait states,
// keeps a one-word last-fetch buffer and latches protocol violations.
module ibus_wait_adapter #(
    parameter int WAIT_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ibus_address,
    input  logic        ibus_read,
    input  logic        ibus_write,
    input  logic [3:0]  ibus_byteenable,
    output logic [31:0] ibus_rddata,
    output logic        ibus_stall,
    output logic [31:0] mem_address,
    input  logic [31:0] mem_rddata,
    input  logic        invalidate,
    output logic        err_abort,
    output logic        err_write
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state_reg;
    logic [29:0]        latched_addr_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               buf_valid_reg;
    logic [31:0]        rddata_reg;
    logic               err_abort_reg;
    logic               err_write_reg;

    logic               addr_match;
    logic               hit;
    logic               unused_inputs;

    assign unused_inputs = ^{ibus_byteenable, ibus_address[1:0]};

    assign addr_match = (ibus_address[31:2] == latched_addr_reg);
    // An invalidate arriving with a matching request forces a refetch.
    assign hit        = buf_valid_reg && addr_match && !invalidate;

    always_comb begin
        ibus_stall = 1'b0;
        if (rst_n) begin
            case (state_reg)
                IDLE:    ibus_stall = ibus_read && !ibus_write && !hit;
                BUSY:    ibus_stall = 1'b1;
                default: ibus_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            latched_addr_reg <= '0;
            cnt_reg          <= '0;
            buf_valid_reg    <= 1'b0;
            rddata_reg       <= '0;
            err_abort_reg    <= 1'b0;
            err_write_reg    <= 1'b0;
        end else begin
            if (ibus_write) begin
                err_write_reg <= 1'b1;
            end
            if (invalidate) begin
                buf_valid_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (!ibus_write && ibus_read && !hit) begin
                        latched_addr_reg <= ibus_address[31:2];
                        cnt_reg          <= CNT_W'(WAIT_CYCLES);
                        buf_valid_reg    <= 1'b0;
                        state_reg        <= BUSY;
                    end
                end
                BUSY: begin
                    if (!ibus_read || !addr_match) begin
                        err_abort_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end else if (cnt_reg == '0) begin
                        rddata_reg    <= mem_rddata;
                        buf_valid_reg <= !invalidate;
                        state_reg     <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign mem_address = {latched_addr_reg, 2'b00};
    assign ibus_rddata = rddata_reg;
    assign err_abort   = err_abort_reg;
    assign err_write   = err_write_reg;

endmodule

// File: tb/tb_ibus_wait_adapter.sv
// Bench for ibus_wait_adapter: two instances (4 and 0 wait states) share the
// CPU-side stimulus and are compared every cycle against a fetch-level model.
module tb_ibus_wait_adapter;

    logic        clk;
    logic        rst_n;
    logic [31:0] ibus_address;
    logic        ibus_read;
    logic        ibus_write;
    logic [3:0]  ibus_byteenable;
    logic        invalidate;

    logic [31:0] rddata   [2];
    logic        stall    [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_rd   [2];
    logic        eab      [2];
    logic        ewr      [2];

    logic [31:0] rom [16];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per instance, a pending fetch with a count of BUSY
    // cycles left before capture, a one-word buffer and two sticky flags.
    int          wait_of  [2] = '{4, 0};
    bit          m_busy   [2];
    bit          m_done   [2];
    int          m_left   [2];
    logic [29:0] m_tag    [2];
    bit          m_valid  [2];
    logic [31:0] m_data   [2];
    bit          m_eab    [2];
    bit          m_ewr    [2];

    bit          s_stall  [2];
    logic [31:0] s_data   [2];

    ibus_wait_adapter #(.WAIT_CYCLES(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .ibus_address(ibus_address),
        .ibus_read(ibus_read), .ibus_write(ibus_write),
        .ibus_byteenable(ibus_byteenable), .ibus_rddata(rddata[0]),
        .ibus_stall(stall[0]), .mem_address(mem_addr[0]),
        .mem_rddata(mem_rd[0]), .invalidate(invalidate),
        .err_abort(eab[0]), .err_write(ewr[0])
    );

    ibus_wait_adapter #(.WAIT_CYCLES(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .ibus_address(ibus_address),
        .ibus_read(ibus_read), .ibus_write(ibus_write),
        .ibus_byteenable(ibus_byteenable), .ibus_rddata(rddata[1]),
        .ibus_stall(stall[1]), .mem_address(mem_addr[1]),
        .mem_rddata(mem_rd[1]), .invalidate(invalidate),
        .err_abort(eab[1]), .err_write(ewr[1])
    );

    assign mem_rd[0] = rom[mem_addr[0][5:2]];
    assign mem_rd[1] = rom[mem_addr[1][5:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i]  = 0;
            m_done[i]  = 0;
            m_left[i]  = 0;
            m_tag[i]   = '0;
            m_valid[i] = 0;
            m_data[i]  = '0;
            m_eab[i]   = 0;
            m_ewr[i]   = 0;
        end
    endtask

    function automatic bit model_stall(int i);
        if (!rst_n)                 return 0;
        if (m_busy[i])              return 1;
        if (m_done[i] || ibus_write) return 0;
        if (!ibus_read)             return 0;
        return !(m_valid[i] && ibus_address[31:2] == m_tag[i] && !invalidate);
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit hit;
            hit = m_valid[i] && ibus_address[31:2] == m_tag[i] && !invalidate;
            if (ibus_write) m_ewr[i] = 1;
            if (m_busy[i]) begin
                if (!ibus_read || ibus_address[31:2] != m_tag[i]) begin
                    m_eab[i]  = 1;
                    m_busy[i] = 0;
                end else if (m_left[i] == 0) begin
                    m_data[i]  = rom[m_tag[i][3:0]];
                    m_valid[i] = 1;
                    m_busy[i]  = 0;
                    m_done[i]  = 1;
                end else begin
                    m_left[i]--;
                end
            end else if (m_done[i]) begin
                m_done[i] = 0;
            end else if (!ibus_write && ibus_read && !hit) begin
                m_tag[i]   = ibus_address[31:2];
                m_left[i]  = wait_of[i];
                m_valid[i] = 0;
                m_busy[i]  = 1;
            end
            if (invalidate) m_valid[i] = 0;
        end
    endtask

    // One bus cycle: check both instances mid-cycle, then advance the model.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            string p;
            p = (i == 0) ? "a" : "b";
            chk({"stall_", p},    32'(stall[i]), 32'(model_stall(i)));
            chk({"rddata_", p},   rddata[i],     m_data[i]);
            chk({"mem_addr_", p}, mem_addr[i],   {m_tag[i], 2'b00});
            chk({"err_abort_", p}, 32'(eab[i]),  32'(m_eab[i]));
            chk({"err_write_", p}, 32'(ewr[i]),  32'(m_ewr[i]));
            s_stall[i] = stall[i];
            s_data[i]  = rddata[i];
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic fetch(input int inst, input logic [31:0] addr,
                         input int exp_cycles, input logic [31:0] exp_data);
        int  cnt;
        bit  done;
        cnt  = 0;
        done = 0;
        ibus_read    = 1'b1;
        ibus_write   = 1'b0;
        ibus_address = addr;
        for (int k = 0; k < 40 && !done; k++) begin
            step();
            if (s_stall[inst]) cnt++;
            else begin
                done = 1;
                chk("fetch_data", s_data[inst], exp_data);
            end
        end
        chk("fetch_completed", 32'(done), 32'd1);
        chk("fetch_stall_cycles", 32'(cnt), 32'(exp_cycles));
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_stall_a", 32'(stall[0]), 32'd0);
        chk("rst_stall_b", 32'(stall[1]), 32'd0);
        chk("rst_rddata_a", rddata[0], 32'd0);
        chk("rst_rddata_b", rddata[1], 32'd0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) rom[k] = 32'h1000_0000 + 32'(k) * 32'h0101_0101;
        rom[0] = 32'h3C01_1234;
        rom[1] = 32'h3421_0001;
        ibus_address    = 32'h8000_0000;
        ibus_read       = 1'b0;
        ibus_write      = 1'b0;
        ibus_byteenable = 4'hF;
        invalidate      = 1'b0;
        rst_n           = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        chk("reset_stall", 32'(stall[0]), 32'd0);
        chk("reset_rddata", rddata[0], 32'd0);
        chk("reset_mem_addr", mem_addr[0], 32'd0);
        chk("reset_err_abort", 32'(eab[0]), 32'd0);
        chk("reset_err_write", 32'(ewr[0]), 32'd0);
        step();

        // miss with four wait states
        fetch(0, 32'h8000_0000, 6, 32'h3C01_1234);
        chk("t1_err_abort", 32'(eab[0]), 32'd0);
        chk("t1_err_write", 32'(ewr[0]), 32'd0);

        // buffered repeat, then a new word
        fetch(0, 32'h8000_0000, 0, 32'h3C01_1234);
        fetch(0, 32'h8000_0004, 6, 32'h3421_0001);

        // request dropped mid-BUSY
        ibus_address = 32'h8000_0008;
        ibus_read    = 1'b1;
        repeat (3) step();
        ibus_read = 1'b0;
        step();
        chk("t3_err_abort", 32'(eab[0]), 32'd1);
        step();
        chk("t3_idle_stall", 32'(s_stall[0]), 32'd0);
        chk("t3_rddata_kept", s_data[0], 32'h3421_0001);
        fetch(0, 32'h8000_0008, 6, rom[2]);

        // write on a read-only bus
        ibus_read    = 1'b0;
        ibus_write   = 1'b1;
        ibus_address = 32'h8000_0010;
        step();
        chk("t4_write_stall", 32'(s_stall[0]), 32'd0);
        chk("t4_err_write", 32'(ewr[0]), 32'd1);
        ibus_write = 1'b0;
        fetch(0, 32'h8000_0008, 0, rom[2]);

        // invalidate then ROM reload
        fetch(0, 32'h8000_0000, 6, 32'h3C01_1234);
        fetch(0, 32'h8000_0000, 0, 32'h3C01_1234);
        ibus_read  = 1'b0;
        invalidate = 1'b1;
        step();
        invalidate = 1'b0;
        rom[0] = 32'hDEAD_BEEF;
        fetch(0, 32'h8000_0000, 6, 32'hDEAD_BEEF);

        // zero wait states, then reset while the slow instance is BUSY
        ibus_read = 1'b0;
        step();
        fetch(1, 32'h8000_0014, 2, rom[5]);
        reset_pulse();
        fetch(0, 32'h8000_0014, 6, rom[5]);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) == 0)
                ibus_address = 32'h8000_0000 + (32'($urandom_range(0, 3)) << 2);
            ibus_read  = ($urandom_range(0, 9) < 8);
            ibus_write = ($urandom_range(0, 19) == 0);
            invalidate = ($urandom_range(0, 19) == 0);
            ibus_byteenable = 4'($urandom);
            if ($urandom_range(0, 15) == 0) rom[$urandom_range(0, 3)] = $urandom;
            step();
            if ($urandom_range(0, 99) == 0) reset_pulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
